alu_sched: RTL and testbench
============================

# alu_sched

Request scheduler and sequencer for the shared 4-bit arithmetic/logic datapath. Two independent requesters present opcode/operand pairs over valid/ready handshakes. A round-robin arbiter grants one request at a time. The block executes it, single-cycle for logic/add/sub and iterative for mul/div, then returns an 8-bit result, flag and requester ID over a valid/ready response channel. It sits between the instruction-issue logic and the ALU and is the only path by which requesters reach the ALU.

## Interface
- WIDTH, 4: operand width; result width is 2*WIDTH; iterative mul/div takes WIDTH cycles
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; one-hot or zero
- req0_opcode / req1_opcode  in  4  opcode for requester 0 / 1
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands for requester 0 / 1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  index of the requester that owns the response
- rsp_result  out  2*WIDTH  result
- rsp_flag  out  1  carry, borrow or div-by-zero, depending on the opcode
- busy  out  1  high whenever state is not IDLE

## Operation
- The FSM has three states: IDLE, EXEC and DONE.
- **Arbitration (IDLE only).**
  - req_ready[i] = (state==IDLE) & grant[i], combinational.
  - If only one req_valid bit is set, that requester is granted.
  - If both are set, grant goes to the requester not named in last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - On acceptance the block captures opcode, a, b and id, and updates last_grant.
- **Opcodes.** Logic results are computed on WIDTH bits and zero-extended.
  - 0000 add: result = a+b; flag = result[WIDTH] (carry).
  - 0001 sub: result = (a−b) mod 2^(2W); flag = (a<b) (borrow).
  - 0010 mul: result = a*b; flag 0.
  - 0011 div: result = {remainder, quotient}.
    - b==0: quotient all ones, remainder = a, flag 1.
    - otherwise flag 0.
  - 0100 and, 0101 or, 0110 not a, 0111 nand, 1000 nor, 1001 xor, 1010 xnor: flag 0.
  - 1011–1111: result 0, flag 0, single-cycle.
- **Transitions.**
  - IDLE→DONE on accept of a single-cycle op.
  - IDLE→EXEC on accept of mul/div.
  - EXEC→DONE when the iteration counter reaches WIDTH−1.
  - DONE→IDLE on rsp_valid & rsp_ready.
- **Mul:** shift-add, one partial-product bit per cycle.
- **Div:** restoring division, one quotient bit per cycle.
- In DONE, rsp_valid=1 and rsp_result/rsp_flag/rsp_id are held stable until rsp_ready is seen.
- Requests are not accepted while busy, including during the DONE handshake cycle.
- Requester inputs are ignored after capture; they may change freely.

## Timing
- Reset values: rsp_valid 0, rsp_result 0, rsp_flag 0, rsp_id 0, req_ready 0, busy 0; state IDLE; counter 0; last_grant 1.
- Accept at edge T.
  - Single-cycle op: rsp_valid is high in the cycle after T.
  - mul/div: WIDTH EXEC cycles, then rsp_valid high in cycle T+WIDTH+1.
- Back-to-back throughput:
  - Single-cycle ops: one per 2 cycles, with rsp_ready held high.
  - mul/div: one per WIDTH+2 cycles.
- rsp_ready low: DONE holds indefinitely and no new grant is issued.
- rst_n asserted mid-operation: the in-flight request and any pending response are discarded, and outputs take reset values immediately.
- The counter wraps only via the EXEC→DONE transition; it is cleared on entry to EXEC.

## Configuration
- ALU_SCHED_ITERATIVE_EN defined:
  - mul/div use the iterative unit.
  - Latency is WIDTH+1 cycles from accept to rsp_valid.
- Undefined:
  - mul/div are computed combinationally and follow the single-cycle path (IDLE→DONE, latency 1).
  - EXEC is unreachable and the counter is removed.
  - Results and flags are identical in both builds.

## Structure
- Shared package alu_sched_pkg holds:
  - opcode localparams OP_ADD … OP_XNOR;
  - the state enum (IDLE, EXEC, DONE);
  - the response struct (id, result, flag).
- One sub-module, alu_sched_muldiv: the iterative multiplier/divider.
  - Ports: start, op, a, b, done, result, flag.
  - Instantiated only under ALU_SCHED_ITERATIVE_EN.
- Arbiter and single-cycle logic stay in the top module.

## Test plan
- Reset then req0: add a=9, b=8 → rsp_valid one cycle after accept; result 8'h11, flag 1, id 0.
- req1: sub a=3, b=5 → result 8'hFE, flag 1, id 1.
- Both valid together, each with two queued requests, rsp_ready always 1 → grant order 0,1,0,1; each response's id matches its owner.
- req0: mul a=15, b=15, with ALU_SCHED_ITERATIVE_EN defined → rsp_valid in cycle T+5; result 8'hE1.
  - Same stimulus with the macro undefined → result 8'hE1 at T+1.
- req0: div a=13, b=4 → result {4'h1, 4'h3}, flag 0.
  - div a=7, b=0 → result {4'h7, 4'hF}, flag 1.
- Start mul, assert rst_n low in the second EXEC cycle → all outputs 0 asynchronously.
  - After release with req0 and req1 both valid, requester 0 is granted.
  - Separately: rsp_ready held low for 10 cycles → response stable, req_ready stays 0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: opcodes, FSM states, response record and single-cycle ALU evaluation shared by alu_sched.
package alu_sched_pkg;
  localparam int W = 4;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_NOR  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_XNOR = 4'hA;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef struct packed {
    logic           id;
    logic [2*W-1:0] result;
    logic           flag;
  } rsp_t;
  // returns {flag, result}; unused opcodes give zero
  function automatic logic [2*W:0] alu_eval(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb, r;
    logic f;
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
    r = '0;
    f = 1'b0;
    case (op)
      OP_ADD:  begin r = ea + eb; f = r[W]; end
      OP_SUB:  begin r = ea - eb; f = a < b; end
      OP_MUL:  r = ea * eb;
      OP_DIV:  begin r = (b == '0) ? {a, {W{1'b1}}} : {a % b, a / b}; f = (b == '0); end
      OP_AND:  r = {{W{1'b0}}, a & b};
      OP_OR:   r = {{W{1'b0}}, a | b};
      OP_NOT:  r = {{W{1'b0}}, ~a};
      OP_NAND: r = {{W{1'b0}}, ~(a & b)};
      OP_NOR:  r = {{W{1'b0}}, ~(a | b)};
      OP_XOR:  r = {{W{1'b0}}, a ^ b};
      OP_XNOR: r = {{W{1'b0}}, ~(a ^ b)};
      default: r = '0;
    endcase
    return {f, r};
  endfunction
endpackage

// File: rtl/alu_sched_muldiv.sv
// alu_sched_muldiv: iterative shift-add multiplier / restoring divider, one bit per cycle.
module alu_sched_muldiv import alu_sched_pkg::*; #(
  parameter int WIDTH = W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag
);
  localparam int CW = $clog2(WIDTH);
  logic               run_q, run_d, div_q, div_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [2*WIDTH-1:0] p_q, p_d, step;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     sum, t, diff;
  logic               ge, is_div;
  // p_q holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    is_div = (op == OP_DIV);
    sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, d_q} : '0);
    t = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    ge = t >= {1'b0, d_q};
    diff = t - {1'b0, d_q};
    step = div_q ? {ge ? diff[WIDTH-1:0] : t[WIDTH-1:0], p_q[WIDTH-2:0], ge} : {sum, p_q[WIDTH-1:1]};
    done = run_q & (cnt_q == CW'(WIDTH - 1));
    result = step;
    flag = div_q & (d_q == '0);
    run_d = start | (run_q & ~done);
    cnt_d = (start | done) ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
    p_d = start ? {{WIDTH{1'b0}}, is_div ? a : b} : run_q ? step : p_q;
    d_d = start ? (is_div ? b : a) : d_q;
    div_d = start ? is_div : div_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      d_q <= '0;
      p_q <= '0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      d_q <= d_d;
      p_q <= p_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin scheduler in front of the shared ALU.
// ALU_SCHED_ITERATIVE_EN selects the multi-cycle mul/div unit; otherwise mul/div are single-cycle.
module alu_sched import alu_sched_pkg::*; #(
  parameter int WIDTH = W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req0_opcode,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [3:0]         req1_opcode,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_flag,
  output logic               busy
);
  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  rsp_t               rsp_q, rsp_d;
  logic [1:0]         grant;
  logic               sel, accept;
  logic [3:0]         op;
  logic [WIDTH-1:0]   a, b;
  logic [2*WIDTH:0]   alu;
`ifdef ALU_SCHED_ITERATIVE_EN
  logic               is_md, md_done, md_flag;
  logic [2*WIDTH-1:0] md_result;
  assign is_md = (op == OP_MUL) | (op == OP_DIV);
  alu_sched_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk(clk), .rst_n(rst_n), .start(accept & is_md), .op(op), .a(a), .b(b),
    .done(md_done), .result(md_result), .flag(md_flag)
  );
  // mul/div never take the combinational path here, so those ALU branches fold away
  assign alu = alu_eval(is_md ? 4'hF : op, a, b);
`else
  assign alu = alu_eval(op, a, b);
`endif
  always_comb begin
    grant[0] = req_valid[0] & (~req_valid[1] | last_grant_q);
    grant[1] = req_valid[1] & (~req_valid[0] | ~last_grant_q);
    req_ready = (state_q == IDLE) ? grant : 2'b00;
    accept = |req_ready;
    sel = grant[1];
    op = sel ? req1_opcode : req0_opcode;
    a = sel ? req1_a : req0_a;
    b = sel ? req1_b : req0_b;
    rsp_valid = (state_q == DONE);
    busy = (state_q != IDLE);
    rsp_id = rsp_q.id;
    rsp_result = rsp_q.result;
    rsp_flag = rsp_q.flag;
  end
  always_comb begin
    state_d = state_q;
    rsp_d = rsp_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = sel;
      rsp_d = '{id: sel, result: alu[2*WIDTH-1:0], flag: alu[2*WIDTH]};
`ifdef ALU_SCHED_ITERATIVE_EN
      state_d = is_md ? EXEC : DONE;
`else
      state_d = DONE;
`endif
    end
`ifdef ALU_SCHED_ITERATIVE_EN
    if (state_q == EXEC && md_done) begin
      state_d = DONE;
      rsp_d.result = md_result;
      rsp_d.flag = md_flag;
    end
`endif
    if (state_q == DONE && rsp_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      rsp_q <= rsp_d;
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: vector table plus scoreboard for alu_sched; latency expectations follow ALU_SCHED_ITERATIVE_EN.
module tb_alu_sched;
  import alu_sched_pkg::*;
`ifdef ALU_SCHED_ITERATIVE_EN
  localparam int MD_LAT = 5;
`else
  localparam int MD_LAT = 1;
`endif
  typedef struct {logic id; logic [3:0] op; logic [3:0] a; logic [3:0] b; logic [7:0] res; logic flag;} vec_t;
  typedef struct {logic id; logic [7:0] res; logic flag;} exp_t;

  logic       clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [3:0] req0_opcode = '0, req0_a = '0, req0_b = '0;
  logic [3:0] req1_opcode = '0, req1_a = '0, req1_b = '0;
  logic [1:0] req_ready;
  logic       rsp_valid, rsp_id, rsp_flag, busy;
  logic [7:0] rsp_result;
  exp_t       sb[$];
  vec_t       vt[$];
  int         vec_cnt = 0, err_cnt = 0;

  alu_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic exp_t model(input logic id, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int x, y, r;
    exp_t e;
    x = a;
    y = b;
    r = 0;
    e.flag = 1'b0;
    case (op)
      4'h0: begin r = x + y; e.flag = (r > 15); end
      4'h1: begin r = (x - y) & 255; e.flag = (x < y); end
      4'h2: r = x * y;
      4'h3: if (y == 0) begin r = x * 16 + 15; e.flag = 1'b1; end else r = (x % y) * 16 + x / y;
      4'h4: r = x & y;
      4'h5: r = x | y;
      4'h6: r = 15 - x;
      4'h7: r = 15 - (x & y);
      4'h8: r = 15 - (x | y);
      4'h9: r = x ^ y;
      4'hA: r = 15 - (x ^ y);
      default: r = 0;
    endcase
    e.id = id;
    e.res = 8'(r);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL sb_unexpected: response id %0d result %0h with nothing outstanding", rsp_id, rsp_result);
        end else begin
          e = sb.pop_front();
          chk("sb_id", rsp_id, e.id);
          chk("sb_result", rsp_result, e.res);
          chk("sb_flag", rsp_flag, e.flag);
        end
      end
      if (req_ready[0] && req_valid[0]) sb.push_back(model(1'b0, req0_opcode, req0_a, req0_b));
      if (req_ready[1] && req_valid[1]) sb.push_back(model(1'b1, req1_opcode, req1_a, req1_b));
    end
  end

  task automatic drive(input logic id, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    if (id) begin req1_opcode = op; req1_a = a; req1_b = b; end
    else begin req0_opcode = op; req0_a = a; req0_b = b; end
  endtask

  task automatic issue(input vec_t v, output int lat);
    logic acc;
    lat = -1;
    acc = 1'b0;
    @(posedge clk); #1;
    drive(v.id, v.op, v.a, v.b);
    req_valid[v.id] = 1'b1;
    for (int i = 0; i < 30 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready[v.id];
    end
    @(posedge clk); #1;
    req_valid[v.id] = 1'b0;
    if (!acc) begin
      miss("accept");
      return;
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drop_on_accept();
    logic [1:0] g;
    for (int c = 0; c < 40 && req_valid != 2'b00; c++) begin
      @(negedge clk);
      g = req_ready & req_valid;
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
    end
    if (req_valid != 2'b00) miss("drop_on_accept");
    req_valid = 2'b00;
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && (sb.size() != 0 || busy); c++) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0 || busy) miss("drain");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_flag"}, rsp_flag, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int lat, k, n0, n1;
    int order[4];
    logic [1:0] g;
    vec_t v;
    logic [3:0] t0_op[2], t0_a[2], t0_b[2], t1_op[2], t1_a[2], t1_b[2];
    vt.push_back('{1'b0, OP_ADD,  4'd9,  4'd8,  8'h11, 1'b1});
    vt.push_back('{1'b1, OP_SUB,  4'd3,  4'd5,  8'hFE, 1'b1});
    vt.push_back('{1'b0, OP_MUL,  4'd15, 4'd15, 8'hE1, 1'b0});
    vt.push_back('{1'b0, OP_DIV,  4'd13, 4'd4,  8'h13, 1'b0});
    vt.push_back('{1'b1, OP_DIV,  4'd7,  4'd0,  8'h7F, 1'b1});
    vt.push_back('{1'b0, OP_AND,  4'hC,  4'hA,  8'h08, 1'b0});
    vt.push_back('{1'b1, OP_OR,   4'hC,  4'hA,  8'h0E, 1'b0});
    vt.push_back('{1'b0, OP_NOT,  4'hC,  4'h0,  8'h03, 1'b0});
    vt.push_back('{1'b0, OP_NAND, 4'hC,  4'hA,  8'h07, 1'b0});
    vt.push_back('{1'b1, OP_NOR,  4'hC,  4'hA,  8'h01, 1'b0});
    vt.push_back('{1'b0, OP_XOR,  4'hC,  4'hA,  8'h06, 1'b0});
    vt.push_back('{1'b1, OP_XNOR, 4'hC,  4'hA,  8'h09, 1'b0});
    vt.push_back('{1'b0, 4'hB,    4'd5,  4'd5,  8'h00, 1'b0});
    vt.push_back('{1'b0, OP_ADD,  4'd7,  4'd8,  8'h0F, 1'b0});
    vt.push_back('{1'b1, OP_SUB,  4'd5,  4'd3,  8'h02, 1'b0});
    vt.push_back('{1'b0, OP_MUL,  4'd0,  4'd9,  8'h00, 1'b0});
    vt.push_back('{1'b1, OP_MUL,  4'd13, 4'd11, 8'h8F, 1'b0});
    vt.push_back('{1'b0, OP_DIV,  4'd15, 4'd1,  8'h0F, 1'b0});
    vt.push_back('{1'b1, OP_DIV,  4'd3,  4'd7,  8'h30, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    foreach (vt[i]) begin
      issue(vt[i], lat);
      chk($sformatf("v%0d_latency", i), lat, (vt[i].op == OP_MUL || vt[i].op == OP_DIV) ? MD_LAT : 1);
      chk($sformatf("v%0d_result", i), rsp_result, vt[i].res);
      chk($sformatf("v%0d_flag", i), rsp_flag, vt[i].flag);
      chk($sformatf("v%0d_id", i), rsp_id, vt[i].id);
    end
    drain();

    // both requesters hold two requests each; grants must alternate starting with 0
    t0_op = '{OP_ADD, OP_XOR}; t0_a = '{4'd1, 4'd5}; t0_b = '{4'd2, 4'd3};
    t1_op = '{OP_SUB, OP_OR};  t1_a = '{4'd9, 4'd1}; t1_b = '{4'd4, 4'd8};
    order = '{9, 9, 9, 9};
    k = 0; n0 = 0; n1 = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 60 && k < 4; c++) begin
      if (n0 < 2) drive(1'b0, t0_op[n0], t0_a[n0], t0_b[n0]);
      if (n1 < 2) drive(1'b1, t1_op[n1], t1_a[n1], t1_b[n1]);
      req_valid = {n1 < 2, n0 < 2};
      @(negedge clk);
      g = req_ready & req_valid;
      if (g[0] && k < 4) begin order[k] = 0; k++; n0++; end
      if (g[1] && k < 4) begin order[k] = 1; k++; n1++; end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), order[i], i % 2);
    drain();

    // stalled response: DONE holds and nothing is granted
    rsp_ready = 1'b0;
    v = '{1'b0, OP_ADD, 4'd2, 4'd3, 8'h05, 1'b0};
    issue(v, lat);
    chk("stall_latency", lat, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        drive(1'b0, OP_XOR, 4'd6, 4'd5);
        drive(1'b1, OP_NAND, 4'd3, 4'd3);
        req_valid = 2'b11;
      end
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_result", rsp_result, 8'h05);
      chk("stall_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drop_on_accept();
    drain();

    // asynchronous reset during a multiply
    @(posedge clk); #1;
    drive(1'b0, OP_MUL, 4'd15, 4'd15);
    req_valid = 2'b01;
    g = 2'b00;
    for (int i = 0; i < 30 && g == 2'b00; i++) begin
      @(negedge clk);
      g = req_ready;
    end
    if (g == 2'b00) miss("mul_accept");
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    sb.delete();
    @(posedge clk); #1;
    drive(1'b0, OP_AND, 4'd3, 4'd5);
    drive(1'b1, OP_OR, 4'd3, 4'd5);
    req_valid = 2'b11;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    drop_on_accept();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
